// File: rtl/btn_adv_gen.sv
// btn_adv_gen: synchronizes and debounces a push-button, emits adv pulses on press and auto-repeat while held
module btn_adv_gen #(
  parameter int DB_CYC   = 4,
  parameter int HOLD_CYC = 8,
  parameter int RPT_CYC  = 2,
  parameter int CW       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic en,
  output logic held,
  output logic adv
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CYC - 1);
  logic s1_q, s2_q;
  logic held_q, held_d, held_p_q;
  logic adv_q, adv_d;
  logic [CW-1:0] dcnt_q, dcnt_d, tcnt_q, tcnt_d;
  state_t state_q, state_d;
  // two-flop synchronizer on the asynchronous button
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1_q, s2_q} <= 2'b00;
    else {s1_q, s2_q} <= {btn_raw, s1_q};
  // debounce: held toggles only after DB_CYC consecutive disagreeing samples
  always_comb begin
    held_d = held_q;
    dcnt_d = '0;
    if (s2_q != held_q) begin
      held_d = (dcnt_q == DB_LAST) ? ~held_q : held_q;
      dcnt_d = (dcnt_q == DB_LAST) ? '0 : dcnt_q + 1'b1;
    end
  end
  // debounce state plus the previous held level used for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      held_q   <= 1'b0;
      held_p_q <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      held_q   <= held_d;
      held_p_q <= held_q;
      dcnt_q   <= dcnt_d;
    end
  // press / delay / repeat sequencing; a pulse is withheld if held drops on this same edge
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q + 1'b1;
    adv_d   = 1'b0;
    if (!held_q || !en) begin
      state_d = IDLE;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tcnt_d = '0;
          if (!held_p_q && held_d) begin
            adv_d   = 1'b1;
            state_d = DELAY;
          end
        end
        DELAY:
          if (tcnt_q == HOLD_LAST && held_d) begin
            adv_d   = 1'b1;
            tcnt_d  = '0;
            state_d = REPEAT;
          end
        REPEAT:
          if (tcnt_q == RPT_LAST && held_d) begin
            adv_d  = 1'b1;
            tcnt_d = '0;
          end
        default: begin
          state_d = IDLE;
          tcnt_d  = '0;
        end
      endcase
    end
  end
  // sequencer registers and the registered advance pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      adv_q   <= adv_d;
    end
  assign held = held_q;
  assign adv  = adv_q;
endmodule

// File: tb/tb_btn_adv_gen.sv
// tb_btn_adv_gen: directed and randomized checks of btn_adv_gen against a behavioural model
module tb_btn_adv_gen;
  localparam int DB = 4, HOLD = 8, RPT = 2;
  logic clk = 1'b0, rst = 1'b1, btn_raw = 1'b0, en = 1'b0;
  logic held, adv;
  int n_chk = 0, n_fail = 0;
  bit m_s1, m_s2, m_held, m_hp, m_adv, m_act;
  int m_t0, k;
  bit win[$];
  int sc_idx, sc_cnt, sc_first, sc_hlast, sc_hseen;
  btn_adv_gen #(.DB_CYC(DB), .HOLD_CYC(HOLD), .RPT_CYC(RPT), .CW(8)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .en(en), .held(held), .adv(adv)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    {m_s1, m_s2, m_held, m_hp, m_adv, m_act} = '0;
    win.delete();
  endtask
  // held flips once the last DB synchronized samples all disagree with it;
  // pulses at 0, HOLD, HOLD+RPT, ... edges after the press while held and enabled
  task automatic model_edge(input bit b, input bit e);
    bit h, hp, hn, p, all;
    int d;
    h = m_held; hp = m_hp; hn = h; p = 0;
    win.push_back(m_s2);
    if (win.size() > DB) void'(win.pop_front());
    if (win.size() == DB) begin
      all = 1;
      foreach (win[i]) if (win[i] == h) all = 0;
      if (all) hn = !h;
    end
    if (!h || !e) m_act = 0;
    else if (!m_act) begin
      if (!hp && hn) begin
        p = 1; m_act = 1; m_t0 = k;
      end
    end else begin
      d = k - m_t0;
      if (hn && (d == HOLD || (d > HOLD && (d - HOLD) % RPT == 0))) p = 1;
    end
    m_hp = h; m_held = hn; m_s2 = m_s1; m_s1 = b; m_adv = p; k++;
  endtask
  task automatic sc_start();
    sc_idx = 0; sc_cnt = 0; sc_first = -1; sc_hlast = -1; sc_hseen = 0;
  endtask
  task automatic step(input bit b, input bit e);
    btn_raw = b; en = e;
    @(posedge clk);
    model_edge(b, e);
    #1;
    check("held", held, m_held);
    check("adv", adv, m_adv);
    if (adv === 1'b1) begin
      if (sc_cnt == 0) sc_first = sc_idx;
      sc_cnt++;
    end
    if (held === 1'b1) begin
      sc_hlast = sc_idx;
      sc_hseen = 1;
    end
    sc_idx++;
  endtask
  task automatic run(input bit b, input bit e, input int n);
    for (int i = 0; i < n; i++) step(b, e);
  endtask
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_held", held, 0);
    check("rst_adv", adv, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    bit b, e;
    int len;
    k = 0;
    model_reset();
    #2;
    check("por_held", held, 0);
    check("por_adv", adv, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    run(0, 1, 8);
    sc_start(); run(1, 1, 31);
    check("hold_cnt", sc_cnt, 10);
    check("hold_first", sc_first, 6);
    run(0, 1, 12);
    sc_start(); run(1, 1, 3); run(0, 1, 15);
    check("glitch3_cnt", sc_cnt, 0);
    check("glitch3_held", sc_hseen, 0);
    sc_start(); run(1, 1, 4); run(0, 1, 16);
    check("glitch4_cnt", sc_cnt, 1);
    check("glitch4_first", sc_first, 6);
    sc_start(); run(1, 1, 6); run(0, 1, 14);
    check("short_cnt", sc_cnt, 1);
    check("short_first", sc_first, 6);
    check("short_hlast", sc_hlast, 10);
    sc_start(); run(1, 0, 10); run(1, 1, 20);
    check("en_late_cnt", sc_cnt, 0);
    run(0, 1, 12);
    sc_start(); run(1, 1, 10);
    check("repress_first", sc_first, 6);
    run(0, 1, 12);
    sc_start(); run(1, 1, 17);
    check("pre_drop_cnt", sc_cnt, 3);
    sc_start(); run(1, 0, 6);
    check("en_drop_cnt", sc_cnt, 0);
    run(0, 1, 12);
    sc_start(); run(1, 1, 17);
    async_reset();
    sc_start(); run(1, 1, 10);
    check("rst_first", sc_first, 6);
    check("rst_cnt", sc_cnt, 1);
    run(0, 1, 12);
    b = 0; e = 1;
    for (int s = 0; s < 200; s++) begin
      b = ~b;
      len = (s % 3 == 0) ? $urandom_range(1, 5) : $urandom_range(1, 30);
      if ($urandom_range(0, 9) == 0) e = ~e;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 29) == 0) e = ~e;
        step(b, e);
      end
      if ($urandom_range(0, 39) == 0) async_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
